updown_modulo_counter: RTL and testbench

Parametrised up/down counter with a programmable terminal value, selectable wrap, saturate or one-shot behaviour, and a registered terminal-count pulse for cascading. It is the general-purpose timing and event counter for datapath and control blocks, replacing fixed full-range counters. An optional enable prescaler slows the count rate without an external divider.

---
 rtl/counter_pkg.sv | 13 +
 rtl/counter_prescaler.sv | 36 +++
 rtl/updown_modulo_counter.sv | 104 ++++++++++
 tb/tb_updown_modulo_counter.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared types and constants for the up/down modulo counter family.
package counter_pkg;

  localparam int unsigned MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_WRAP    = 2'b00,
    MODE_SAT     = 2'b01,
    MODE_ONESHOT = 2'b10,
    MODE_RSVD    = 2'b11
  } count_mode_e;

endpackage : counter_pkg

// File: rtl/counter_prescaler.sv
// Enable prescaler: emits a tick every (div+1) enabled cycles.
// Instantiated by updown_modulo_counter only when COUNTER_PRESCALE_EN is defined.
module counter_prescaler #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] div,
  output logic         tick
);

  logic [W-1:0] pre_q, pre_d;

  assign tick = (pre_q == div);

  // Phase only advances on enabled cycles and restarts on each tick.
  always_comb begin
    pre_d = pre_q;
    if (clear) begin
      pre_d = '0;
    end else if (enable) begin
      pre_d = tick ? '0 : pre_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

endmodule : counter_prescaler

// File: rtl/updown_modulo_counter.sv
// Up/down counter with programmable terminal value and WRAP/SAT/ONESHOT behaviour.
// Optional enable prescaler compiled in with COUNTER_PRESCALE_EN.
module updown_modulo_counter
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_value,
  input  logic                  enable,
  input  logic                  direction,
  input  logic [MODE_W-1:0]     mode,
  input  logic [WIDTH-1:0]      limit,
`ifdef COUNTER_PRESCALE_EN
  input  logic [PRESCALE_W-1:0] prescale_div,
`endif
  output logic [WIDTH-1:0]      count,
  output logic                  at_term,
  output logic                  tc_pulse,
  output logic                  halted
);

  logic [WIDTH-1:0] count_q, count_d;
  logic             halted_q, halted_d;
  logic             tc_q, tc_d;
  logic             step_tick;
  logic             step;
  count_mode_e      mode_e;

  assign mode_e = count_mode_e'(mode);

`ifdef COUNTER_PRESCALE_EN
  counter_prescaler #(
    .W (PRESCALE_W)
  ) u_prescaler (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (clear | load),
    .enable (enable & ~halted_q),
    .div    (prescale_div),
    .tick   (step_tick)
  );
`else
  logic [PRESCALE_W-1:0] unused_prescale;
  assign unused_prescale = '0;
  assign step_tick       = 1'b1;
`endif

  assign at_term = direction ? (count_q >= limit) : (count_q == '0);
  assign step    = enable & step_tick & ~halted_q & ~clear & ~load;

  // Priority: clear > load > step; terminal handling depends on mode.
  always_comb begin
    count_d  = count_q;
    halted_d = halted_q;
    tc_d     = 1'b0;
    if (clear) begin
      count_d  = '0;
      halted_d = 1'b0;
    end else if (load) begin
      count_d  = load_value;
      halted_d = 1'b0;
    end else if (step) begin
      if (at_term) begin
        case (mode_e)
          MODE_SAT: begin
            count_d = count_q;
          end
          MODE_ONESHOT: begin
            halted_d = 1'b1;
            tc_d     = 1'b1;
          end
          default: begin
            count_d = direction ? '0 : limit;
            tc_d    = 1'b1;
          end
        endcase
      end else begin
        count_d = direction ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= '0;
      halted_q <= 1'b0;
      tc_q     <= 1'b0;
    end else begin
      count_q  <= count_d;
      halted_q <= halted_d;
      tc_q     <= tc_d;
    end
  end

  assign count    = count_q;
  assign tc_pulse = tc_q;
  assign halted   = halted_q;

endmodule : updown_modulo_counter

// File: tb/tb_updown_modulo_counter.sv
// Directed-vector bench for updown_modulo_counter (WIDTH = 8).
module tb_updown_modulo_counter;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned PW    = 4;

  logic             clk;
  logic             rst_n;
  logic             clear;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic             enable;
  logic             direction;
  logic [1:0]       mode;
  logic [WIDTH-1:0] limit;
  logic [PW-1:0]    prescale_div;
  logic [WIDTH-1:0] count;
  logic             at_term;
  logic             tc_pulse;
  logic             halted;

  int total;
  int bad;

  typedef struct {
    string      name;
    logic       clr;
    logic       ld;
    logic [7:0] ldv;
    logic       en;
    logic       dir;
    logic [1:0] md;
    logic [7:0] lim;
    logic [7:0] e_count;
    logic       e_tc;
    logic       e_halted;
    logic       e_at;
  } vec_t;

  vec_t vecs[$];

  updown_modulo_counter #(
    .WIDTH      (WIDTH),
    .PRESCALE_W (PW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (clear),
    .load         (load),
    .load_value   (load_value),
    .enable       (enable),
    .direction    (direction),
    .mode         (mode),
    .limit        (limit),
`ifdef COUNTER_PRESCALE_EN
    .prescale_div (prescale_div),
`endif
    .count        (count),
    .at_term      (at_term),
    .tc_pulse     (tc_pulse),
    .halted       (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input string name, input logic clr, input logic ld, input logic [7:0] ldv,
                     input logic en, input logic dir, input logic [1:0] md, input logic [7:0] lim,
                     input logic [7:0] ec, input logic etc, input logic eh, input logic eat);
    vec_t v;
    v.name = name; v.clr = clr; v.ld = ld; v.ldv = ldv; v.en = en; v.dir = dir;
    v.md = md; v.lim = lim; v.e_count = ec; v.e_tc = etc; v.e_halted = eh; v.e_at = eat;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic clr, input logic ld, input logic [7:0] ldv,
                       input logic en, input logic dir, input logic [1:0] md, input logic [7:0] lim);
    clear = clr; load = ld; load_value = ldv; enable = en;
    direction = dir; mode = md; limit = lim;
  endtask

  // Apply inputs, take one edge, check all outputs 1 time unit after the edge.
  task automatic run_vec(input vec_t v);
    drive(v.clr, v.ld, v.ldv, v.en, v.dir, v.md, v.lim);
    @(posedge clk);
    #1;
    chk({v.name, ".count"},  32'(count),    32'(v.e_count));
    chk({v.name, ".tc"},     32'(tc_pulse), 32'(v.e_tc));
    chk({v.name, ".halted"}, 32'(halted),   32'(v.e_halted));
    chk({v.name, ".at_term"},32'(at_term),  32'(v.e_at));
  endtask

  initial begin
    total = 0;
    bad   = 0;
    prescale_div = '0;
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 8'h00);
    rst_n = 1'b0;
    #12;
    chk("rst.count",   32'(count),    32'h0);
    chk("rst.tc",      32'(tc_pulse), 32'h0);
    chk("rst.halted",  32'(halted),   32'h0);
    chk("rst.at_down", 32'(at_term),  32'h1);
    direction = 1'b1;
    limit     = 8'd9;
    #1;
    chk("rst.at_up",   32'(at_term),  32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // WRAP up, limit 9, 11 steps from 0
    for (int i = 1; i <= 11; i++) begin
      logic [7:0] c;
      c = (i <= 9) ? 8'(i) : 8'(i - 10);
      add($sformatf("wrap_up%0d", i), 0, 0, 8'h00, 1, 1, 2'b00, 8'd9,
          c, (i == 10), 0, (c == 8'd9));
    end
    // SAT down: load 2 then 5 steps
    add("sat_load", 0, 1, 8'd2, 0, 0, 2'b01, 8'd9, 8'd2, 0, 0, 0);
    add("sat_d1",   0, 0, 8'd0, 1, 0, 2'b01, 8'd9, 8'd1, 0, 0, 0);
    for (int i = 2; i <= 5; i++)
      add($sformatf("sat_d%0d", i), 0, 0, 8'd0, 1, 0, 2'b01, 8'd9, 8'd0, 0, 0, 1);
    // ONESHOT up, limit 3
    add("os_clr", 1, 0, 8'd0, 0, 1, 2'b10, 8'd3, 8'd0, 0, 0, 0);
    add("os_1",   0, 0, 8'd0, 1, 1, 2'b10, 8'd3, 8'd1, 0, 0, 0);
    add("os_2",   0, 0, 8'd0, 1, 1, 2'b10, 8'd3, 8'd2, 0, 0, 0);
    add("os_3",   0, 0, 8'd0, 1, 1, 2'b10, 8'd3, 8'd3, 0, 0, 1);
    add("os_halt",0, 0, 8'd0, 1, 1, 2'b10, 8'd3, 8'd3, 1, 1, 1);
    add("os_hold1",0,0, 8'd0, 1, 1, 2'b10, 8'd3, 8'd3, 0, 1, 1);
    add("os_hold2",0,0, 8'd0, 1, 1, 2'b10, 8'd3, 8'd3, 0, 1, 1);
    add("os_ld1", 0, 1, 8'd1, 1, 1, 2'b10, 8'd3, 8'd1, 0, 0, 0);
    // Simultaneous events
    add("clr_ld",  1, 1, 8'h55, 1, 1, 2'b00, 8'hFF, 8'h00, 0, 0, 0);
    add("ld_en",   0, 1, 8'h20, 1, 1, 2'b00, 8'hFF, 8'h20, 0, 0, 0);
    add("ld_80",   0, 1, 8'h80, 0, 1, 2'b00, 8'h10, 8'h80, 0, 0, 1);
    add("over_wrap",0,0, 8'h00, 1, 1, 2'b00, 8'h10, 8'h00, 1, 0, 0);
    // WRAP down from 0 reloads limit; reserved mode acts as WRAP
    add("wd_lim",  0, 0, 8'h00, 1, 0, 2'b00, 8'd5, 8'd5, 1, 0, 0);
    add("wd_dec",  0, 0, 8'h00, 1, 0, 2'b11, 8'd5, 8'd4, 0, 0, 0);
    // limit 0 counting up: every step terminal
    add("l0_a",    0, 0, 8'h00, 1, 1, 2'b11, 8'd0, 8'd0, 1, 0, 1);
    add("l0_b",    0, 0, 8'h00, 1, 1, 2'b00, 8'd0, 8'd0, 1, 0, 1);
    add("idle",    0, 0, 8'h00, 0, 1, 2'b00, 8'd0, 8'd0, 0, 0, 1);
    // Non-terminal down step across modulo boundary is unreachable; check 0xFF up wrap at limit 0xFF
    add("ld_fe",   0, 1, 8'hFE, 0, 1, 2'b00, 8'hFF, 8'hFE, 0, 0, 0);
    add("fe_ff",   0, 0, 8'h00, 1, 1, 2'b00, 8'hFF, 8'hFF, 0, 0, 1);
    add("ff_00",   0, 0, 8'h00, 1, 1, 2'b00, 8'hFF, 8'h00, 1, 0, 0);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Asynchronous reset mid-count, between edges
    drive(0, 1, 8'h37, 0, 1, 2'b00, 8'hFF);
    @(posedge clk);
    #1;
    chk("pre_rst.count", 32'(count), 32'h37);
    drive(0, 0, 8'h00, 1, 1, 2'b00, 8'h38);
    @(posedge clk);
    #1;
    chk("pre_rst.step", 32'(count), 32'h38);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.count",  32'(count),    32'h0);
    chk("arst.tc",     32'(tc_pulse), 32'h0);
    chk("arst.halted", 32'(halted),   32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("arst.first_step", 32'(count), 32'h1);

`ifdef COUNTER_PRESCALE_EN
    // Prescaler: div 2 -> step on every third enabled cycle
    drive(1, 0, 8'h00, 0, 1, 2'b00, 8'hFF);
    prescale_div = 4'd2;
    @(posedge clk);
    #1;
    drive(0, 0, 8'h00, 1, 1, 2'b00, 8'hFF);
    for (int i = 1; i <= 9; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("pre_c%0d", i), 32'(count), 32'(i / 3));
    end
    @(posedge clk);
    #1;
    chk("pre_ph1", 32'(count), 32'd3);
    enable = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("pre_frozen", 32'(count), 32'd3);
    enable = 1'b1;
    @(posedge clk);
    #1;
    chk("pre_ph2", 32'(count), 32'd3);
    @(posedge clk);
    #1;
    chk("pre_tick", 32'(count), 32'd4);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_updown_modulo_counter
